// File: rtl/booth_seq_mult_if.sv
// booth_seq_mult_if: operand/product handshake bundle for booth_seq_mult
//   in_valid/in_ready/in_a/in_b : operand pair handshake (master -> slave)
//   abort                       : cancel the operation in flight
//   out_valid/out_ready/product : product handshake (slave -> master)
//   busy                        : slave is retiring Booth digits
interface booth_seq_mult_if #(
    parameter int WIDTH  = 24,
    parameter int HIDDEN = 1
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-HIDDEN-1:0]   in_a;
    logic [WIDTH-HIDDEN-1:0]   in_b;
    logic                      abort;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*WIDTH-1:0]        product;
    logic                      busy;
    modport master (
        output in_valid, in_a, in_b, abort, out_ready,
        input  in_ready, out_valid, product, busy
    );
    modport slave (
        input  in_valid, in_a, in_b, abort, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-4 Booth unsigned multiplier, DPC digits per clock
//   clk, rst : clock, asynchronous active-high reset
//   bus      : booth_seq_mult_if slave (operands in, product out, abort, busy)
module booth_seq_mult #(
    parameter int WIDTH  = 24,
    parameter int HIDDEN = 1,
    parameter int DPC    = 1
) (
    input logic              clk,
    input logic              rst,
    booth_seq_mult_if.slave  bus
);
    localparam int NDIG = WIDTH / 2 + 1;
    localparam int AW   = 2 * WIDTH + 2;
    localparam int BSW  = 2 * NDIG + 1 + 2 * DPC;
    localparam int IW   = $clog2(NDIG + DPC + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT           state, nextState;
    logic [WIDTH-1:0] opA, opB;
    logic [AW-1:0]   acc, accNext, aSh, m;
    logic [BSW-1:0]  bSh;
    logic [2:0]      d;
    logic [IW-1:0]   idx;
    logic [2*WIDTH-1:0] productReg;
    logic            accept, lastStep;

    if (HIDDEN != 0) begin : gHidden
        assign opA = {1'b1, bus.in_a};
        assign opB = {1'b1, bus.in_b};
    end else begin : gPlain
        assign opA = bus.in_a;
        assign opB = bus.in_b;
    end

    assign accept   = state == IDLE && bus.in_valid && !bus.abort;
    assign lastStep = idx + IW'(DPC) >= IW'(NDIG);

    assign bus.in_ready  = state == IDLE;
    assign bus.busy      = state == BUSY;
    assign bus.out_valid = state == DONE;
    assign bus.product   = productReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = accept ? BUSY : IDLE;
            BUSY:    nextState = bus.abort ? IDLE : lastStep ? DONE : BUSY;
            DONE:    nextState = (bus.abort || bus.out_ready) ? IDLE : DONE;
            default: nextState = IDLE;
        endcase
    end

    // aSh holds A pre-weighted by 4^idx and bSh holds the recoding window of B
    // already shifted down, so digit j of this step reads bSh[2j+2:2j] and
    // its weight is aSh << 2j; no barrel shifter on the accumulator.
    always_comb begin
        accNext = acc;
        d = '0;
        m = '0;
        for (int j = 0; j < DPC; j++) begin
            d = bSh[2*j +: 3];
            m = aSh << (2 * j);
            accNext = accNext + ((d == 3'b011) ? m << 1 :
                                 (d == 3'b100) ? -(m << 1) :
                                 (d == 3'b001 || d == 3'b010) ? m :
                                 (d == 3'b101 || d == 3'b110) ? -m : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            aSh        <= '0;
            bSh        <= '0;
            idx        <= '0;
            productReg <= '0;
        end else if (accept) begin
            acc <= '0;
            aSh <= AW'(opA);
            bSh <= {{(BSW-WIDTH-1){1'b0}}, opB, 1'b0};
            idx <= '0;
        end else if (state == BUSY) begin
            acc <= accNext;
            aSh <= aSh << (2 * DPC);
            bSh <= bSh >> (2 * DPC);
            idx <= idx + IW'(DPC);
            if (lastStep && !bus.abort) productReg <= accNext[2*WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: scoreboard bench over four booth_seq_mult configurations
module tb_booth_seq_mult;
    typedef logic [3:0][47:0] expT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inValid = 1'b0, abort = 1'b0, outReady = 1'b0;
    logic [23:0] inA = '0, inB = '0;
    logic [3:0] ov, ir, bz;
    logic [3:0][47:0] pr;
    int total = 0, bad = 0;
    int lat [4] = '{13, 13, 7, 4};
    expT sbq[$];

    always #5 clk = ~clk;

    booth_seq_mult_if #(.WIDTH(24), .HIDDEN(0)) if0();
    booth_seq_mult_if #(.WIDTH(24), .HIDDEN(1)) if1();
    booth_seq_mult_if #(.WIDTH(24), .HIDDEN(0)) if2();
    booth_seq_mult_if #(.WIDTH(24), .HIDDEN(0)) if3();

    booth_seq_mult #(.WIDTH(24), .HIDDEN(0), .DPC(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    booth_seq_mult #(.WIDTH(24), .HIDDEN(1), .DPC(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    booth_seq_mult #(.WIDTH(24), .HIDDEN(0), .DPC(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
    booth_seq_mult #(.WIDTH(24), .HIDDEN(0), .DPC(4)) u3 (.clk(clk), .rst(rst), .bus(if3));

    assign if0.in_valid = inValid; assign if0.in_a = inA;       assign if0.in_b = inB;
    assign if1.in_valid = inValid; assign if1.in_a = inA[22:0]; assign if1.in_b = inB[22:0];
    assign if2.in_valid = inValid; assign if2.in_a = inA;       assign if2.in_b = inB;
    assign if3.in_valid = inValid; assign if3.in_a = inA;       assign if3.in_b = inB;
    assign if0.abort = abort; assign if1.abort = abort; assign if2.abort = abort; assign if3.abort = abort;
    assign if0.out_ready = outReady; assign if1.out_ready = outReady;
    assign if2.out_ready = outReady; assign if3.out_ready = outReady;

    assign ov = {if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
    assign ir = {if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};
    assign bz = {if3.busy, if2.busy, if1.busy, if0.busy};
    assign pr = {if3.product, if2.product, if1.product, if0.product};

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic expT expOf(input logic [23:0] a, input logic [23:0] b);
        expT e;
        logic [47:0] full, hid;
        full = {24'b0, a} * {24'b0, b};
        hid  = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = {full, full, hid, full};
        return e;
    endfunction

    task automatic runOp(input logic [23:0] a, input logic [23:0] b, input int hold);
        int n;
        logic [3:0] seen;
        expT e;
        sbq.push_back(expOf(a, b));
        inA = a;
        inB = b;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        checkVal("acceptState", {ir, bz}, {4'h0, 4'hF});
        seen = '0;
        n = 0;
        while (seen != 4'hF && n < 40) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 4; i++) begin
                if (ov[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    checkVal($sformatf("latency%0d", i), 64'(n), 64'(lat[i]));
                    checkVal($sformatf("product%0d", i), pr[i], sbq[0][i]);
                end
            end
        end
        if (seen != 4'hF) checkVal("timeout", seen, 4'hF);
        e = sbq.pop_front();
        inValid = hold > 0;
        inA = ~a;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkVal("holdHandshake", {ov, ir, bz}, {4'hF, 4'h0, 4'h0});
            for (int i = 0; i < 4; i++) checkVal($sformatf("holdProduct%0d", i), pr[i], e[i]);
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkVal("retire", {ov, ir, bz}, {4'h0, 4'hF, 4'h0});
    endtask

    initial begin
        logic [3:0] anyValid;
        repeat (2) @(negedge clk);
        checkVal("resetState", {ov, ir, bz}, {4'h0, 4'hF, 4'h0});
        for (int i = 0; i < 4; i++) checkVal($sformatf("resetProduct%0d", i), pr[i], 48'h0);
        rst = 1'b0;
        runOp(24'hFFFFFF, 24'hFFFFFF, 0);
        runOp(24'h000000, 24'h000000, 0);
        runOp(24'h123456, 24'hABCDEF, 5);
        runOp(24'h000001, 24'hFFFFFF, 0);
        runOp(24'hAAAAAA, 24'h555555, 0);
        // abort in IDLE beats in_valid
        inValid = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        abort = 1'b0;
        checkVal("abortIdle", {ov, ir, bz}, {4'h0, 4'hF, 4'h0});
        // abort on the sixth busy edge
        inA = 24'h00BEEF;
        inB = 24'h00CAFE;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkVal("abortBusy", {ov, ir, bz}, {4'h0, 4'hF, 4'h0});
        anyValid = '0;
        repeat (15) begin
            @(negedge clk);
            anyValid = anyValid | ov;
        end
        checkVal("abortNoValid", anyValid, 4'h0);
        runOp(24'd3, 24'd5, 0);
        // reset in the middle of BUSY
        inA = 24'h777777;
        inB = 24'h888888;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkVal("rstMidBusy", {ov, ir, bz}, {4'h0, 4'hF, 4'h0});
        for (int i = 0; i < 4; i++) checkVal($sformatf("rstProduct%0d", i), pr[i], 48'h0);
        @(negedge clk);
        rst = 1'b0;
        runOp(24'h3C3C3C, 24'hC3C3C3, 0);
        for (int k = 0; k < 300; k++) runOp(24'($urandom), 24'($urandom), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 24: multiplier/multiplicand magnitude width in bits, including the hidden bit; legal range 4..64.
REQ-002 SHALL have parameter HIDDEN, default 1: when 1, operands carry WIDTH-1 fraction bits and a constant 1 is prepended as MSB; when 0, operands are full WIDTH-bit unsigned values.
REQ-003 SHALL have parameter DPC, default 1: radix-4 Booth digits retired per clock; legal values 1, 2, 4.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operand pair present.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-008 SHALL have port in_a, input, WIDTH-HIDDEN bits: multiplicand.
REQ-009 SHALL have port in_b, input, WIDTH-HIDDEN bits: multiplier.
REQ-010 SHALL have port abort, input, 1 bit: synchronous cancel of the current operation.
REQ-011 SHALL have port out_valid, output, 1 bit: product valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts product.
REQ-013 SHALL have port product, output, 2*WIDTH bits: unsigned product.
REQ-014 SHALL have port busy, output, 1 bit: high while in state BUSY.

Function
REQ-015 SHALL define operand A = {HIDDEN?1:none, in_a} and operand B likewise; both are WIDTH-bit unsigned.
REQ-016 SHALL recode B, zero-extended to 2*NDIG+1 bits with an implicit 0 below the LSB, into NDIG = floor(WIDTH/2)+1 radix-4 Booth digits in {-2,-1,0,+1,+2}; for WIDTH=24 this gives 13 digits.
REQ-017 SHALL form each partial product as digit*A in WIDTH+2-bit two's complement and accumulate it at weight 4^k into a 2*WIDTH+2-bit signed accumulator.
REQ-018 SHALL implement states IDLE, BUSY, DONE.
REQ-019 IDLE: in_ready=1; when in_valid=1 the block SHALL latch the operands, clear the accumulator, set the digit index to 0, and enter BUSY.
REQ-020 BUSY: per edge, SHALL retire digits index..index+DPC-1 (digits >= NDIG contribute 0) and advance index by DPC.
REQ-021 BUSY SHALL last exactly C = ceil(NDIG/DPC) edges, then SHALL enter DONE; out_valid rises on the edge C cycles after the accept edge.
REQ-022 DONE: out_valid=1 and product = accumulator[2*WIDTH-1:0]; product SHALL be held stable until the edge where out_ready=1, on which the block SHALL return to IDLE.
REQ-023 in_ready SHALL be 0 in BUSY and DONE; there is no back-to-back overlap, so the next accept is earliest 1 cycle after the product handshake.
REQ-024 abort=1 in BUSY or DONE SHALL force IDLE on the next edge, deassert out_valid, and discard the result; abort in IDLE SHALL have priority over in_valid, and no accept occurs.
REQ-025 The accumulator's final value SHALL be non-negative and SHALL equal A*B exactly; bits above 2*WIDTH-1 are zero and SHALL be dropped.
REQ-026 The product output SHALL be registered; it is don't-care outside DONE but SHALL NOT change while out_valid=1.

Reset
REQ-027 While rst=1, asynchronously: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator and index=0.
REQ-028 rst asserted mid-BUSY or in DONE SHALL drop the operation with no product delivered; the first accept SHALL be possible on the first edge after rst deasserts.

Verification
REQ-029 HIDDEN=0, WIDTH=24, DPC=1, A=B=0xFFFFFF -> out_valid exactly 13 cycles after accept, product=0xFFFFFE000001.
REQ-030 HIDDEN=1, WIDTH=24, in_a=in_b=0 -> product=0x400000000000; in_a=in_b=0x7FFFFF -> product=0xFFFFFE000001.
REQ-031 DPC=2, then DPC=4, random 10k operand pairs vs reference A*B -> all match; latency 7 and 4 cycles respectively.
REQ-032 out_ready held 0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-033 abort at BUSY cycle 6 -> IDLE next edge, out_valid never asserts; next operand pair (3x5, HIDDEN=0) -> product=15.
REQ-034 rst pulse mid-BUSY -> outputs at reset values immediately; post-reset operation correct.
